// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: tick-paced joystick tank mover with per-axis obstacle/opponent scan and video passthrough
// Ports: clk, rst (async active-low); select_mode (1 = running, 0 = hold at spawn);
//   video timing in -> *_out registered once, plus select_out;
//   joy_x/joy_y joystick samples; op_x/op_y opponent top-left; obs_bus packed {bottom,top,right,left} rectangles;
//   xpos/ypos own top-left, direction (0 up,1 down,2 left,3 right), pos_valid commit pulse,
//   blocked_x/blocked_y axis rejected at last commit, busy while scanning.
module tank_motion_ctrl #(
  parameter int POS_W  = 10,
  parameter int CNT_W  = 24,
  parameter int DELAY  = 1000000,
  parameter int STEP   = 1,
  parameter int X_INIT = 300,
  parameter int Y_INIT = 700,
  parameter int X_MIN  = 2,
  parameter int X_MAX  = 719,
  parameter int Y_MIN  = 2,
  parameter int Y_MAX  = 702,
  parameter int TANK_W = 48,
  parameter int TANK_H = 64,
  parameter int JOY_LO = 400,
  parameter int JOY_HI = 600,
  parameter int N_OBS  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     select_mode,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic                     hblnk,
  input  logic                     vblnk,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [11:0]              rgb_in,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [11:0]              rgb_out,
  output logic                     select_out,
  input  logic [POS_W-1:0]         joy_x,
  input  logic [POS_W-1:0]         joy_y,
  input  logic [POS_W-1:0]         op_x,
  input  logic [POS_W-1:0]         op_y,
  input  logic [N_OBS*4*POS_W-1:0] obs_bus,
  output logic [POS_W-1:0]         xpos,
  output logic [POS_W-1:0]         ypos,
  output logic [1:0]               direction,
  output logic                     pos_valid,
  output logic                     blocked_x,
  output logic                     blocked_y,
  output logic                     busy
);
  localparam int K_W = $clog2(N_OBS + 2);
  localparam int E_W = POS_W + 2;
  localparam logic signed [E_W-1:0] STP = E_W'(STEP);
  localparam logic signed [E_W-1:0] XL = E_W'(X_MIN);
  localparam logic signed [E_W-1:0] XH = E_W'(X_MAX);
  localparam logic signed [E_W-1:0] YL = E_W'(Y_MIN);
  localparam logic signed [E_W-1:0] YH = E_W'(Y_MAX);
  localparam logic [E_W-1:0] TW = E_W'(TANK_W);
  localparam logic [E_W-1:0] TH = E_W'(TANK_H);
  localparam logic [POS_W-1:0] J_LO = POS_W'(JOY_LO);
  localparam logic [POS_W-1:0] J_HI = POS_W'(JOY_HI);
  localparam logic [POS_W-1:0] X0 = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y0 = POS_W'(Y_INIT);
  typedef enum logic [2:0] {HOLD, WAIT, SCAN_X, SCAN_Y, COMMIT} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0] k;
  logic signed [E_W-1:0] dx, dy, dx_in, dy_in, sum_x, sum_y;
  logic [POS_W-1:0] op_xl, op_yl, cand_x, cand_y, x_res, y_res, cx, cy;
  logic [E_W-1:0] rl [2**K_W];
  logic [E_W-1:0] rr [2**K_W];
  logic [E_W-1:0] rt [2**K_W];
  logic [E_W-1:0] rb [2**K_W];
  logic tick, last, hit, rej_x, rej_y;
  // Scan table: static obstacles, then the latched opponent box at index N_OBS; spare slots never scanned.
  for (genvar i = 0; i < 2**K_W; i++) begin : g_rect
    if (i < N_OBS) begin : g_obs
      assign rl[i] = {2'b0, obs_bus[i*4*POS_W +: POS_W]};
      assign rr[i] = {2'b0, obs_bus[i*4*POS_W + POS_W +: POS_W]};
      assign rt[i] = {2'b0, obs_bus[i*4*POS_W + 2*POS_W +: POS_W]};
      assign rb[i] = {2'b0, obs_bus[i*4*POS_W + 3*POS_W +: POS_W]};
    end else if (i == N_OBS) begin : g_opp
      assign rl[i] = {2'b0, op_xl};
      assign rr[i] = {2'b0, op_xl} + TW;
      assign rt[i] = {2'b0, op_yl};
      assign rb[i] = {2'b0, op_yl} + TH;
    end else begin : g_nil
      assign rl[i] = '0;
      assign rr[i] = '0;
      assign rt[i] = '0;
      assign rb[i] = '0;
    end
  end
  assign tick = cnt == CNT_W'(DELAY - 1);
  assign last = k == K_W'(N_OBS);
  assign busy = state == SCAN_X || state == SCAN_Y;
  assign dx_in = joy_x < J_LO ? STP : joy_x > J_HI ? -STP : '0;
  assign dy_in = joy_y < J_LO ? STP : joy_y > J_HI ? -STP : '0;
  // Wide signed sums so a step below zero clamps to the border instead of wrapping.
  assign sum_x = $signed({2'b0, xpos}) + dx;
  assign sum_y = $signed({2'b0, ypos}) + dy;
  assign cand_x = sum_x < XL ? XL[POS_W-1:0] : sum_x > XH ? XH[POS_W-1:0] : sum_x[POS_W-1:0];
  assign cand_y = sum_y < YL ? YL[POS_W-1:0] : sum_y > YH ? YH[POS_W-1:0] : sum_y[POS_W-1:0];
  assign x_res = |dx && !rej_x ? cand_x : xpos;
  assign y_res = |dy && !rej_y ? cand_y : ypos;
  // The Y scan tests against the already resolved x, which is what makes wall sliding work.
  assign cx = state == SCAN_X ? cand_x : x_res;
  assign cy = state == SCAN_X ? ypos : cand_y;
  assign hit = {2'b0, cx} < rr[k] && {2'b0, cx} + TW > rl[k] && {2'b0, cy} < rb[k] && {2'b0, cy} + TH > rt[k];
  always_comb begin
    state_nx = state;
    case (state)
      HOLD:    state_nx = WAIT;
      WAIT:    if (tick) state_nx = |dx_in ? SCAN_X : |dy_in ? SCAN_Y : COMMIT;
      SCAN_X:  if (last) state_nx = |dy ? SCAN_Y : COMMIT;
      SCAN_Y:  if (last) state_nx = COMMIT;
      default: state_nx = WAIT;
    endcase
    if (!select_mode) state_nx = HOLD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HOLD;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {hcount_out, vcount_out, hblnk_out, vblnk_out, hsync_out, vsync_out, rgb_out, select_out} <= '0;
      cnt <= '0;
      k <= '0;
      dx <= '0;
      dy <= '0;
      op_xl <= '0;
      op_yl <= '0;
      rej_x <= 1'b0;
      rej_y <= 1'b0;
      xpos <= X0;
      ypos <= Y0;
      direction <= 2'd0;
      pos_valid <= 1'b0;
      blocked_x <= 1'b0;
      blocked_y <= 1'b0;
    end else begin
      {hcount_out, vcount_out, hblnk_out, vblnk_out, hsync_out, vsync_out, rgb_out, select_out} <=
        {hcount, vcount, hblnk, vblnk, hsync, vsync, rgb_in, select_mode};
      cnt <= state == HOLD || !select_mode || tick ? '0 : cnt + 1'b1;
      pos_valid <= 1'b0;
      if (!select_mode || state == HOLD) begin
        xpos <= X0;
        ypos <= Y0;
        k <= '0;
      end else if (state == WAIT && tick) begin
        dx <= dx_in;
        dy <= dy_in;
        op_xl <= op_x;
        op_yl <= op_y;
        k <= '0;
        rej_x <= 1'b0;
        rej_y <= 1'b0;
      end else if (busy) begin
        k <= last ? '0 : k + 1'b1;
        rej_x <= rej_x | (state == SCAN_X && hit);
        rej_y <= rej_y | (state == SCAN_Y && hit);
      end else if (state == COMMIT) begin
        xpos <= x_res;
        ypos <= y_res;
        blocked_x <= rej_x;
        blocked_y <= rej_y;
        pos_valid <= 1'b1;
        if (!(|dy) && |dx && !rej_x) direction <= dx[E_W-1] ? 2'd2 : 2'd3;
        else if (!(|dx) && |dy && !rej_y) direction <= dy[E_W-1] ? 2'd0 : 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed scenario bench for tank_motion_ctrl
module tb_tank_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic select_mode = 1'b0;
  logic [10:0] hcount = '0, hcount_out;
  logic [9:0] vcount = '0, vcount_out;
  logic hblnk = 1'b0, vblnk = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic hblnk_out, vblnk_out, hsync_out, vsync_out, select_out;
  logic [11:0] rgb_in = '0, rgb_out;
  logic [9:0] joy_x = 10'd500, joy_y = 10'd500;
  logic [9:0] op_x = 10'd600, op_y = 10'd400;
  logic [79:0] obs_bus = {10'd10, 10'd0, 10'd520, 10'd500, 10'd200, 10'd100, 10'd150, 10'd100};
  logic [9:0] xpos, ypos;
  logic [1:0] direction;
  logic pos_valid, blocked_x, blocked_y, busy;
  int passed = 0, total = 0;
  tank_motion_ctrl #(.DELAY(16), .N_OBS(2)) dut (
    .clk(clk), .rst(rst), .select_mode(select_mode),
    .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out), .select_out(select_out),
    .joy_x(joy_x), .joy_y(joy_y), .op_x(op_x), .op_y(op_y), .obs_bus(obs_bus),
    .xpos(xpos), .ypos(ypos), .direction(direction), .pos_valid(pos_valid),
    .blocked_x(blocked_x), .blocked_y(blocked_y), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic wait_commit();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = pos_valid;
    end
    if (!seen) begin
      total++;
      $display("FAIL commit_timeout: pos_valid=0 after 64 cycles, required 1");
    end
  endtask
  task automatic wait_busy();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    if (!seen) begin
      total++;
      $display("FAIL busy_timeout: busy=0 after 64 cycles, required 1");
    end
  endtask
  task automatic move(input logic [9:0] jx, input logic [9:0] jy);
    joy_x = jx;
    joy_y = jy;
    wait_commit();
  endtask
  task automatic move_to(input logic [9:0] tx, input logic [9:0] ty);
    logic [9:0] p;
    for (int i = 0; i < 1000 && xpos != tx; i++) begin
      p = xpos;
      move(xpos < tx ? 10'd100 : 10'd900, 10'd500);
      if (xpos == p) break;
    end
    for (int i = 0; i < 1000 && ypos != ty; i++) begin
      p = ypos;
      move(10'd500, ypos < ty ? 10'd100 : 10'd900);
      if (ypos == p) break;
    end
    total++; if (xpos !== tx || ypos !== ty) $display("FAIL reach: got (%0d,%0d) required (%0d,%0d)", xpos, ypos, tx, ty); else passed++;
  endtask
  task automatic test_reset();
    rgb_in = 12'h5A5;
    hcount = 11'd77;
    repeat (2) @(negedge clk);
    total++; if (xpos !== 10'd300 || ypos !== 10'd700) $display("FAIL rst_pos: got (%0d,%0d) required (300,700)", xpos, ypos); else passed++;
    total++; if (direction !== 2'd0 || busy !== 1'b0 || pos_valid !== 1'b0) $display("FAIL rst_flags: dir=%0d busy=%0d pv=%0d required 0/0/0", direction, busy, pos_valid); else passed++;
    total++; if (blocked_x !== 1'b0 || blocked_y !== 1'b0) $display("FAIL rst_blocked: got %0d/%0d required 0/0", blocked_x, blocked_y); else passed++;
    total++; if (rgb_out !== 12'h0 || hcount_out !== 11'd0 || select_out !== 1'b0) $display("FAIL rst_video: rgb=%h hc=%0d sel=%0d required 0/0/0", rgb_out, hcount_out, select_out); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (rgb_out !== 12'h5A5 || hcount_out !== 11'd77) $display("FAIL pass_video: rgb=%h hc=%0d required 5a5/77", rgb_out, hcount_out); else passed++;
    total++; if (xpos !== 10'd300 || ypos !== 10'd700 || busy !== 1'b0) $display("FAIL hold_pos: got (%0d,%0d) busy=%0d required (300,700) 0", xpos, ypos, busy); else passed++;
  endtask
  task automatic test_free_move();
    int n = 0;
    select_mode = 1'b1;
    joy_x = 10'd100;
    joy_y = 10'd500;
    wait_busy();
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 3) $display("FAIL busy_len: got %0d cycles required 3", n); else passed++;
    total++; if (pos_valid !== 1'b0) $display("FAIL commit_gap: pos_valid=%0d required 0", pos_valid); else passed++;
    @(negedge clk);
    total++; if (pos_valid !== 1'b1 || xpos !== 10'd301 || ypos !== 10'd700) $display("FAIL free_move: pv=%0d (%0d,%0d) required 1 (301,700)", pos_valid, xpos, ypos); else passed++;
    total++; if (direction !== 2'd3 || blocked_x !== 1'b0 || select_out !== 1'b1) $display("FAIL free_flags: dir=%0d bx=%0d sel=%0d required 3/0/1", direction, blocked_x, select_out); else passed++;
    joy_x = 10'd500;
    @(negedge clk);
    total++; if (pos_valid !== 1'b0) $display("FAIL pulse_width: pos_valid=%0d required 0", pos_valid); else passed++;
  endtask
  task automatic test_reset_mid_scan();
    joy_x = 10'd100;
    wait_busy();
    #2 rst = 1'b0;
    #1;
    total++; if (xpos !== 10'd300 || ypos !== 10'd700) $display("FAIL async_pos: got (%0d,%0d) required (300,700)", xpos, ypos); else passed++;
    total++; if (busy !== 1'b0 || direction !== 2'd0) $display("FAIL async_flags: busy=%0d dir=%0d required 0/0", busy, direction); else passed++;
    @(negedge clk);
    rst = 1'b1;
    joy_x = 10'd500;
    wait_commit();
  endtask
  task automatic test_dir();
    move(10'd400, 10'd600);
    total++; if (xpos !== 10'd300 || ypos !== 10'd700 || direction !== 2'd0) $display("FAIL joy_edge: (%0d,%0d) dir=%0d required (300,700) 0", xpos, ypos, direction); else passed++;
    move(10'd399, 10'd601);
    total++; if (xpos !== 10'd301 || ypos !== 10'd699 || direction !== 2'd0) $display("FAIL diag: (%0d,%0d) dir=%0d required (301,699) 0", xpos, ypos, direction); else passed++;
    move(10'd500, 10'd100);
    total++; if (ypos !== 10'd700 || direction !== 2'd1) $display("FAIL dir_down: y=%0d dir=%0d required 700/1", ypos, direction); else passed++;
    move(10'd500, 10'd900);
    total++; if (ypos !== 10'd699 || direction !== 2'd0) $display("FAIL dir_up: y=%0d dir=%0d required 699/0", ypos, direction); else passed++;
    move(10'd900, 10'd500);
    total++; if (xpos !== 10'd300 || direction !== 2'd2) $display("FAIL dir_left: x=%0d dir=%0d required 300/2", xpos, direction); else passed++;
    repeat (4) move(10'd500, 10'd100);
    total++; if (ypos !== 10'd702 || blocked_y !== 1'b0 || direction !== 2'd1) $display("FAIL clamp_ymax: y=%0d by=%0d dir=%0d required 702/0/1", ypos, blocked_y, direction); else passed++;
  endtask
  task automatic test_opponent();
    move_to(10'd551, 10'd400);
    move(10'd100, 10'd500);
    total++; if (xpos !== 10'd552 || blocked_x !== 1'b0 || direction !== 2'd3) $display("FAIL opp_touch: x=%0d bx=%0d dir=%0d required 552/0/3", xpos, blocked_x, direction); else passed++;
    move(10'd500, 10'd100);
    move(10'd100, 10'd500);
    total++; if (xpos !== 10'd552 || ypos !== 10'd401 || blocked_x !== 1'b1) $display("FAIL opp_block: (%0d,%0d) bx=%0d required (552,401) 1", xpos, ypos, blocked_x); else passed++;
    total++; if (direction !== 2'd1 || blocked_y !== 1'b0) $display("FAIL opp_dir: dir=%0d by=%0d required 1/0", direction, blocked_y); else passed++;
  endtask
  task automatic test_slide();
    move_to(10'd52, 10'd149);
    move(10'd500, 10'd100);
    move(10'd100, 10'd100);
    total++; if (xpos !== 10'd52 || blocked_x !== 1'b1) $display("FAIL slide_x: x=%0d bx=%0d required 52/1", xpos, blocked_x); else passed++;
    total++; if (ypos !== 10'd151 || blocked_y !== 1'b0) $display("FAIL slide_y: y=%0d by=%0d required 151/0", ypos, blocked_y); else passed++;
    total++; if (direction !== 2'd1) $display("FAIL slide_dir: dir=%0d required 1", direction); else passed++;
  endtask
  task automatic test_clamp();
    move_to(10'd3, 10'd2);
    move(10'd900, 10'd500);
    total++; if (xpos !== 10'd2 || direction !== 2'd2) $display("FAIL to_corner: x=%0d dir=%0d required 2/2", xpos, direction); else passed++;
    move(10'd900, 10'd900);
    total++; if (pos_valid !== 1'b1 || xpos !== 10'd2 || ypos !== 10'd2) $display("FAIL clamp_pos: pv=%0d (%0d,%0d) required 1 (2,2)", pos_valid, xpos, ypos); else passed++;
    total++; if (blocked_x !== 1'b0 || blocked_y !== 1'b0 || direction !== 2'd2) $display("FAIL clamp_flags: bx=%0d by=%0d dir=%0d required 0/0/2", blocked_x, blocked_y, direction); else passed++;
  endtask
  task automatic test_mode_drop();
    int n = 0;
    joy_x = 10'd100;
    joy_y = 10'd500;
    wait_busy();
    select_mode = 1'b0;
    rgb_in = 12'hABC;
    #1;
    total++; if (rgb_out !== 12'h5A5) $display("FAIL rgb_latency: rgb=%h required 5a5", rgb_out); else passed++;
    @(negedge clk);
    total++; if (xpos !== 10'd300 || ypos !== 10'd700 || busy !== 1'b0) $display("FAIL drop_pos: (%0d,%0d) busy=%0d required (300,700) 0", xpos, ypos, busy); else passed++;
    total++; if (rgb_out !== 12'hABC || select_out !== 1'b0 || pos_valid !== 1'b0) $display("FAIL drop_video: rgb=%h sel=%0d pv=%0d required abc/0/0", rgb_out, select_out, pos_valid); else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n += int'(pos_valid);
    end
    total++; if (n !== 0 || xpos !== 10'd300) $display("FAIL hold_quiet: pulses=%0d x=%0d required 0/300", n, xpos); else passed++;
  endtask
  initial begin
    test_reset();
    test_free_move();
    test_reset_mid_scan();
    test_dir();
    test_opponent();
    test_slide();
    test_clamp();
    test_mode_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
